// File: rtl/stage4_field_dict_ctrl_pkg.sv
// Shared constants and payload types for the stage-4 field dictionary controller.
package stage4_field_dict_ctrl_pkg;

  localparam int unsigned FAST_MESSAGE_BITS = 344;
  localparam int unsigned FIELD_W           = 8;
  localparam int unsigned PMAP_W            = 16;
  localparam int unsigned LANES             = 3;
  localparam int unsigned ERR_CNT_W         = 16;

  // PMAP occupies the top 16 message bits; bit 15 of the PMAP is pmap_b.
  localparam int unsigned PMAP_B = 343;
  localparam int unsigned PMAP_E = 328;

  // Value bytes are consumed from the top down in PID, MC, MT order.
  localparam int unsigned FIELD0_HI = 327;
  localparam int unsigned FIELD1_HI = 319;
  localparam int unsigned FIELD2_HI = 311;

  // PMAP bit meanings (bit index within the 16-bit PMAP).
  localparam int unsigned PMAP_VALID_BIT = 15;
  localparam int unsigned PMAP_PID_BIT   = 14;
  localparam int unsigned PMAP_MC_BIT    = 13;
  localparam int unsigned PMAP_MT_BIT    = 12;

  // Legal PMAP: required-one bit set and every bit under this mask zero.
  localparam logic [PMAP_W-1:0] PMAP_LEGAL_SET  = 16'h8000;
  localparam logic [PMAP_W-1:0] PMAP_LEGAL_ZERO = 16'h0FFF;

  localparam logic [FIELD_W-1:0]   PID_RST     = 8'h00;
  localparam logic [FIELD_W-1:0]   MC_RST      = 8'h00;
  localparam logic [FIELD_W-1:0]   MT_RST      = 8'h00;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [FIELD_W-1:0] pid;
    logic [FIELD_W-1:0] mc;
    logic [FIELD_W-1:0] mt;
  } dict_t;

  localparam dict_t DICT_RST = '{pid: PID_RST, mc: MC_RST, mt: MT_RST};

  typedef struct packed {
    logic [PMAP_W-1:0]  pmap;
    logic [FIELD_W-1:0] f0;
    logic [FIELD_W-1:0] f1;
    logic [FIELD_W-1:0] f2;
  } lane_in_t;

  function automatic logic [1:0] popcount3(input logic [LANES-1:0] v);
    popcount3 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/stage4_field_dict_ctrl_lane.sv
// Combinational single-lane resolver: PMAP decode, value unpacking, dictionary update.
module stage4_lane_resolve
  import stage4_field_dict_ctrl_pkg::*;
(
  input  logic     lane_en,
  input  lane_in_t lin,
  input  dict_t    dict_in,
  output dict_t    res_c,
  output dict_t    dict_out_c,
  output logic     err_c
);

  logic               legal;
  logic               upd;
  logic               pid_p;
  logic               mc_p;
  logic               mt_p;
  logic [FIELD_W-1:0] mc_src;
  logic [FIELD_W-1:0] mt_src;

  // Decode PMAP and pick the packed byte each present field consumes.
  always_comb begin
    legal  = lin.pmap[PMAP_VALID_BIT] && ((lin.pmap & PMAP_LEGAL_ZERO) == '0)
             && ((lin.pmap & PMAP_LEGAL_SET) == PMAP_LEGAL_SET);
    upd    = lane_en && legal;
    pid_p  = !lin.pmap[PMAP_PID_BIT];
    mc_p   = !lin.pmap[PMAP_MC_BIT];
    mt_p   = !lin.pmap[PMAP_MT_BIT];
    mc_src = pid_p ? lin.f1 : lin.f0;
    unique case ({pid_p, mc_p})
      2'b11:   mt_src = lin.f2;
      2'b00:   mt_src = lin.f0;
      default: mt_src = lin.f1;
    endcase
  end

  // Merge present values over the incoming dictionary for legal, enabled lanes.
  always_comb begin
    res_c = dict_in;
    if (upd) begin
      if (pid_p) res_c.pid = lin.f0;
      if (mc_p)  res_c.mc  = mc_src;
      if (mt_p)  res_c.mt  = mt_src;
    end
  end

  assign dict_out_c = res_c;
  assign err_c      = lane_en && !legal;

endmodule

// File: rtl/stage4_field_dict_ctrl.sv
// Stage-4 field dictionary controller: three chained lane resolvers behind a one-deep output register.
module stage4_field_dict_ctrl
  import stage4_field_dict_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LANES-1:0]             in_lane,
  input  logic [FAST_MESSAGE_BITS-1:0] in_msg_1,
  input  logic [FAST_MESSAGE_BITS-1:0] in_msg_2,
  input  logic [FAST_MESSAGE_BITS-1:0] in_msg_3,
  input  logic                         dict_clear,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_lane,
  output logic [LANES-1:0]             out_err,
  output logic [FAST_MESSAGE_BITS-1:0] out_msg_1,
  output logic [FAST_MESSAGE_BITS-1:0] out_msg_2,
  output logic [FAST_MESSAGE_BITS-1:0] out_msg_3,
  output logic [FIELD_W-1:0]           out_pid_1,
  output logic [FIELD_W-1:0]           out_pid_2,
  output logic [FIELD_W-1:0]           out_pid_3,
  output logic [FIELD_W-1:0]           out_mc_1,
  output logic [FIELD_W-1:0]           out_mc_2,
  output logic [FIELD_W-1:0]           out_mc_3,
  output logic [FIELD_W-1:0]           out_mt_1,
  output logic [FIELD_W-1:0]           out_mt_2,
  output logic [FIELD_W-1:0]           out_mt_3,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  localparam int unsigned SUM_W = ERR_CNT_W + 1;

  dict_t              dict_q;
  dict_t              dchain [LANES+1];
  dict_t              res    [LANES];
  lane_in_t           lin    [LANES];
  logic [LANES-1:0]   err_c;
  logic               accept;
  logic [SUM_W-1:0]   cnt_sum;
  logic [ERR_CNT_W-1:0] cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign lin[0] = '{pmap: in_msg_1[PMAP_B:PMAP_E], f0: in_msg_1[FIELD0_HI -: FIELD_W],
                    f1: in_msg_1[FIELD1_HI -: FIELD_W], f2: in_msg_1[FIELD2_HI -: FIELD_W]};
  assign lin[1] = '{pmap: in_msg_2[PMAP_B:PMAP_E], f0: in_msg_2[FIELD0_HI -: FIELD_W],
                    f1: in_msg_2[FIELD1_HI -: FIELD_W], f2: in_msg_2[FIELD2_HI -: FIELD_W]};
  assign lin[2] = '{pmap: in_msg_3[PMAP_B:PMAP_E], f0: in_msg_3[FIELD0_HI -: FIELD_W],
                    f1: in_msg_3[FIELD1_HI -: FIELD_W], f2: in_msg_3[FIELD2_HI -: FIELD_W]};

  assign dchain[0] = dict_q;

  stage4_lane_resolve u_lane1 (
    .lane_en   (in_lane[0]),
    .lin       (lin[0]),
    .dict_in   (dchain[0]),
    .res_c     (res[0]),
    .dict_out_c(dchain[1]),
    .err_c     (err_c[0])
  );

  stage4_lane_resolve u_lane2 (
    .lane_en   (in_lane[1]),
    .lin       (lin[1]),
    .dict_in   (dchain[1]),
    .res_c     (res[1]),
    .dict_out_c(dchain[2]),
    .err_c     (err_c[1])
  );

  stage4_lane_resolve u_lane3 (
    .lane_en   (in_lane[2]),
    .lin       (lin[2]),
    .dict_in   (dchain[2]),
    .res_c     (res[2]),
    .dict_out_c(dchain[3]),
    .err_c     (err_c[2])
  );

  // Saturating add of this beat's error popcount.
  always_comb begin
    cnt_sum  = {1'b0, err_cnt} + SUM_W'(popcount3(err_c));
    cnt_next = cnt_sum[ERR_CNT_W] ? ERR_CNT_MAX : cnt_sum[ERR_CNT_W-1:0];
  end

  // Output register: load on accept, drop valid on drain, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_err   <= '0;
      out_msg_1 <= '0;
      out_msg_2 <= '0;
      out_msg_3 <= '0;
      out_pid_1 <= '0;
      out_pid_2 <= '0;
      out_pid_3 <= '0;
      out_mc_1  <= '0;
      out_mc_2  <= '0;
      out_mc_3  <= '0;
      out_mt_1  <= '0;
      out_mt_2  <= '0;
      out_mt_3  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_lane  <= in_lane;
      out_err   <= err_c;
      out_msg_1 <= in_msg_1;
      out_msg_2 <= in_msg_2;
      out_msg_3 <= in_msg_3;
      out_pid_1 <= res[0].pid;
      out_pid_2 <= res[1].pid;
      out_pid_3 <= res[2].pid;
      out_mc_1  <= res[0].mc;
      out_mc_2  <= res[1].mc;
      out_mc_3  <= res[2].mc;
      out_mt_1  <= res[0].mt;
      out_mt_2  <= res[1].mt;
      out_mt_3  <= res[2].mt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Dictionary state: clear wins over the beat's write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      dict_q <= DICT_RST;
    end else if (dict_clear) begin
      dict_q <= DICT_RST;
    end else if (accept) begin
      dict_q <= dchain[LANES];
    end
  end

  // Illegal-PMAP counter, advanced once per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept) begin
      err_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_stage4_field_dict_ctrl.sv
// Self-checking bench for stage4_field_dict_ctrl: directed table, handshake corners, random vs. reference model.
module tb_stage4_field_dict_ctrl;
  import stage4_field_dict_ctrl_pkg::*;

  localparam int unsigned MB = FAST_MESSAGE_BITS;
  localparam int unsigned CW = FAST_MESSAGE_BITS;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [2:0]    in_lane;
  logic [MB-1:0] in_msg_1, in_msg_2, in_msg_3;
  logic          dict_clear;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_lane, out_err;
  logic [MB-1:0] out_msg_1, out_msg_2, out_msg_3;
  logic [7:0]    out_pid_1, out_pid_2, out_pid_3;
  logic [7:0]    out_mc_1, out_mc_2, out_mc_3;
  logic [7:0]    out_mt_1, out_mt_2, out_mt_3;
  logic [15:0]   err_cnt;

  stage4_field_dict_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_lane(in_lane),
    .in_msg_1(in_msg_1), .in_msg_2(in_msg_2), .in_msg_3(in_msg_3),
    .dict_clear(dict_clear), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane(out_lane), .out_err(out_err),
    .out_msg_1(out_msg_1), .out_msg_2(out_msg_2), .out_msg_3(out_msg_3),
    .out_pid_1(out_pid_1), .out_pid_2(out_pid_2), .out_pid_3(out_pid_3),
    .out_mc_1(out_mc_1), .out_mc_2(out_mc_2), .out_mc_3(out_mc_3),
    .out_mt_1(out_mt_1), .out_mt_2(out_mt_2), .out_mt_3(out_mt_3),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the registered outputs and dictionary should hold.
  logic          m_valid;
  logic [2:0]    m_lane, m_err;
  logic [MB-1:0] m_msg [3];
  logic [7:0]    m_out [3][3];
  logic [7:0]    m_dict [3];
  int            m_cnt;

  typedef struct packed {
    logic [2:0]        lane;
    logic [2:0][15:0]  pm;
    logic [2:0][23:0]  by;
    logic              clr;
    logic [2:0][23:0]  res;
    logic [2:0]        err;
    logic [15:0]       cnt;
  } vec_t;

  vec_t tbl [6];

  function automatic void chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [MB-1:0] mk(logic [15:0] pm, logic [23:0] by);
    logic [MB-1:0] m;
    m = '0;
    m[PMAP_B:PMAP_E] = pm;
    m[FIELD0_HI -: 24] = by;
    return m;
  endfunction

  function automatic logic [MB-1:0] rnd_msg();
    logic [351:0] t;
    logic [15:0]  pm;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    pm = {1'b1, 3'($urandom_range(0, 7)), 12'h000};
      2:       pm = {1'b1, 3'($urandom_range(0, 7)), 12'(1 << $urandom_range(0, 11))};
      default: pm = 16'($urandom);
    endcase
    t[PMAP_B:PMAP_E] = pm;
    return t[MB-1:0];
  endfunction

  // Spec-level behaviour: PMAP legality, in-order byte consumption, dictionary forwarding.
  task automatic model_update();
    logic [MB-1:0] msgs [3];
    logic [15:0]   pm;
    logic          legal;
    logic [2:0]    e;
    int            k;
    int            nerr;
    if (rst) begin
      m_valid = 1'b0; m_lane = '0; m_err = '0; m_cnt = 0;
      for (int n = 0; n < 3; n++) begin
        m_msg[n] = '0; m_dict[n] = 8'h00;
        for (int f = 0; f < 3; f++) m_out[n][f] = 8'h00;
      end
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        msgs[0] = in_msg_1; msgs[1] = in_msg_2; msgs[2] = in_msg_3;
        e = '0; nerr = 0;
        for (int n = 0; n < 3; n++) begin
          pm = msgs[n][PMAP_B:PMAP_E];
          legal = pm[15] && (pm[11:0] == 12'h000);
          if (in_lane[n] && legal) begin
            k = 0;
            for (int f = 0; f < 3; f++) begin
              if (!pm[14-f]) begin
                m_dict[f] = msgs[n][327 - 8*k -: 8];
                k++;
              end
            end
          end
          if (in_lane[n] && !legal) begin
            e[n] = 1'b1;
            nerr++;
          end
          for (int f = 0; f < 3; f++) m_out[n][f] = m_dict[f];
          m_msg[n] = msgs[n];
        end
        m_cnt   = (m_cnt + nerr > 65535) ? 65535 : m_cnt + nerr;
        m_valid = 1'b1;
        m_lane  = in_lane;
        m_err   = e;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (dict_clear) for (int f = 0; f < 3; f++) m_dict[f] = 8'h00;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", CW'(out_valid), CW'(m_valid));
    chk("out_lane", CW'(out_lane), CW'(m_lane));
    chk("out_err", CW'(out_err), CW'(m_err));
    chk("err_cnt", CW'(err_cnt), CW'(m_cnt));
    chk("out_msg_1", out_msg_1, m_msg[0]);
    chk("out_msg_2", out_msg_2, m_msg[1]);
    chk("out_msg_3", out_msg_3, m_msg[2]);
    chk("vals_1", CW'({out_pid_1, out_mc_1, out_mt_1}), CW'({m_out[0][0], m_out[0][1], m_out[0][2]}));
    chk("vals_2", CW'({out_pid_2, out_mc_2, out_mt_2}), CW'({m_out[1][0], m_out[1][1], m_out[1][2]}));
    chk("vals_3", CW'({out_pid_3, out_mc_3, out_mt_3}), CW'({m_out[2][0], m_out[2][1], m_out[2][2]}));
  endtask

  // One clock: check in_ready mid-cycle, advance model, check registers after the edge.
  task automatic step();
    @(negedge clk);
    if (!rst) chk("in_ready", CW'(in_ready), CW'(!m_valid || out_ready));
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_vec(int i, logic [2:0] lane, logic [15:0] p1, logic [15:0] p2, logic [15:0] p3,
                         logic [23:0] b1, logic [23:0] b2, logic [23:0] b3, logic clr,
                         logic [23:0] r1, logic [23:0] r2, logic [23:0] r3,
                         logic [2:0] err, logic [15:0] cnt);
    tbl[i].lane = lane;
    tbl[i].pm[0] = p1; tbl[i].pm[1] = p2; tbl[i].pm[2] = p3;
    tbl[i].by[0] = b1; tbl[i].by[1] = b2; tbl[i].by[2] = b3;
    tbl[i].clr = clr;
    tbl[i].res[0] = r1; tbl[i].res[1] = r2; tbl[i].res[2] = r3;
    tbl[i].err = err;
    tbl[i].cnt = cnt;
  endtask

  initial begin
    // Directed vectors, applied back-to-back from a freshly reset dictionary.
    set_vec(0, 3'b011, 16'h8000, 16'hF000, 16'h8000, 24'h112233, 24'h000000, 24'hAABBCC, 1'b0,
            24'h112233, 24'h112233, 24'h112233, 3'b000, 16'd0);
    set_vec(1, 3'b101, 16'hB000, 16'h0000, 16'h1234, 24'h5A0000, 24'h000000, 24'h000000, 1'b0,
            24'h5A2233, 24'h5A2233, 24'h5A2233, 3'b100, 16'd1);
    set_vec(2, 3'b001, 16'hB000, 16'h8000, 16'h8000, 24'h770000, 24'h010203, 24'h040506, 1'b1,
            24'h772233, 24'h772233, 24'h772233, 3'b000, 16'd1);
    set_vec(3, 3'b001, 16'hF000, 16'h8000, 16'h8000, 24'h999999, 24'h000000, 24'h000000, 1'b0,
            24'h000000, 24'h000000, 24'h000000, 3'b000, 16'd1);
    set_vec(4, 3'b000, 16'h8000, 16'h0000, 16'hFFFF, 24'h999999, 24'h999999, 24'h999999, 1'b0,
            24'h000000, 24'h000000, 24'h000000, 3'b000, 16'd1);
    set_vec(5, 3'b111, 16'hC000, 16'h8001, 16'hA000, 24'h445500, 24'h000000, 24'h667700, 1'b0,
            24'h004455, 24'h004455, 24'h664477, 3'b010, 16'd2);

    m_valid = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_lane = '0; dict_clear = 1'b0; out_ready = 1'b0;
    in_msg_1 = '0; in_msg_2 = '0; in_msg_3 = '0;
    step();
    step();
    chk("reset_out_valid", CW'(out_valid), CW'(1'b0));
    chk("reset_err_cnt", CW'(err_cnt), CW'(16'h0000));
    chk("reset_pid_1", CW'(out_pid_1), CW'(8'h00));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_lane = tbl[i].lane; dict_clear = tbl[i].clr;
      in_msg_1 = mk(tbl[i].pm[0], tbl[i].by[0]);
      in_msg_2 = mk(tbl[i].pm[1], tbl[i].by[1]);
      in_msg_3 = mk(tbl[i].pm[2], tbl[i].by[2]);
      step();
      chk($sformatf("tbl%0d_lane1", i), CW'({out_pid_1, out_mc_1, out_mt_1}), CW'(tbl[i].res[0]));
      chk($sformatf("tbl%0d_lane2", i), CW'({out_pid_2, out_mc_2, out_mt_2}), CW'(tbl[i].res[1]));
      chk($sformatf("tbl%0d_lane3", i), CW'({out_pid_3, out_mc_3, out_mt_3}), CW'(tbl[i].res[2]));
      chk($sformatf("tbl%0d_err", i), CW'(out_err), CW'(tbl[i].err));
      chk($sformatf("tbl%0d_cnt", i), CW'(err_cnt), CW'(tbl[i].cnt));
      chk($sformatf("tbl%0d_lane", i), CW'(out_lane), CW'(tbl[i].lane));
    end
    dict_clear = 1'b0;

    // Backpressure: beat B offered for three stalled cycles, then taken exactly once.
    in_lane = 3'b001; in_msg_2 = '0; in_msg_3 = '0;
    in_msg_1 = mk(16'h8000, 24'hA1A2A3);
    step();
    in_msg_1 = mk(16'h8000, 24'hB1B2B3);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_in_ready", CW'(in_ready), CW'(1'b0));
      chk("bp_hold_pid", CW'(out_pid_1), CW'(8'hA1));
    end
    out_ready = 1'b1;
    step();
    chk("bp_reload_pid", CW'(out_pid_1), CW'(8'hB1));
    chk("bp_reload_valid", CW'(out_valid), CW'(1'b1));
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", CW'(out_valid), CW'(1'b0));

    // Reset while stalled with a pending beat and a coincident clear.
    in_valid = 1'b1; in_msg_1 = mk(16'h8000, 24'hC1C2C3);
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1; dict_clear = 1'b1;
    step();
    chk("rst_out_valid", CW'(out_valid), CW'(1'b0));
    rst = 1'b0; dict_clear = 1'b0;
    in_msg_1 = mk(16'hF000, 24'h000000);
    step();
    chk("rst_dict_pid", CW'(out_pid_1), CW'(8'h00));
    chk("rst_dict_mt", CW'(out_mt_1), CW'(8'h00));

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      dict_clear = ($urandom_range(0, 9) == 0);
      in_lane    = 3'($urandom_range(0, 7));
      in_msg_1   = rnd_msg();
      in_msg_2   = rnd_msg();
      in_msg_3   = rnd_msg();
      step();
    end

    // Counter saturation: all three lanes illegal on every beat.
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; dict_clear = 1'b0; in_lane = 3'b111;
    in_msg_1 = mk(16'h0000, 24'h0); in_msg_2 = mk(16'h0000, 24'h0); in_msg_3 = mk(16'h0000, 24'h0);
    for (int c = 0; c < 21845; c++) step();
    chk("sat_reach", CW'(err_cnt), CW'(16'hFFFF));
    step();
    chk("sat_hold", CW'(err_cnt), CW'(16'hFFFF));
    rst = 1'b1; step(); rst = 1'b0;
    chk("sat_rst", CW'(err_cnt), CW'(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
